dbg_uart_rx: RTL and testbench

//  Serial byte receiver, 8N1 (8E1 optional), LSB first. Sits directly upstream of dbgu32.

---
 rtl/dbg_uart_rx_pkg.sv | 27 ++
 rtl/dbg_uart_baud.sv | 27 ++
 rtl/dbg_uart_rx.sv | 197 +++++++++++++++++++
 tb/tb_dbg_uart_rx.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/dbg_uart_rx_pkg.sv
// Shared definitions for the debug UART blocks: state encodings and bit-timing math.
// The TX block is expected to reuse the divider helpers and counter width.
package dbg_uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } uart_state_e;

  localparam int unsigned BAUD_W = 16;

  // Clocks per bit, rounded to nearest.
  function automatic int unsigned uart_div(input int unsigned clk_freq,
                                           input int unsigned uart_freq);
    return (clk_freq + uart_freq / 2) / uart_freq;
  endfunction

  function automatic int unsigned uart_half(input int unsigned clk_freq,
                                            input int unsigned uart_freq);
    return uart_div(clk_freq, uart_freq) / 2;
  endfunction

endpackage

// File: rtl/dbg_uart_baud.sv
// Loadable bit-timing down-counter; tick is high while the count sits at zero.
// Shared between the RX and (future) TX debug UART blocks.
module dbg_uart_baud #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             tick
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tick = (cnt == '0);

endmodule

// File: rtl/dbg_uart_rx.sv
// Debug UART receiver (8N1, LSB first) feeding dbgu32 with 1-cycle byte strobes.
// Define DBG_UART_RX_PARITY_EN for 8E1 framing with even-parity checking.
//
// state     | meaning
// ST_IDLE   | line idle, waiting for a low level on rx_s
// ST_START  | half-bit wait, re-check start bit at its middle
// ST_DATA   | sample 8 data bits at bit centres, LSB first
// ST_PARITY | sample the even-parity bit (parity build only)
// ST_STOP   | sample stop bit, emit valid / frame_err / parity_err
// ST_BREAK  | line stuck low after a framing error, wait for high
module dbg_uart_rx
  import dbg_uart_rx_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 1000000,
  parameter int unsigned UART_FREQ = 115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int unsigned DIV  = uart_div(CLK_FREQ, UART_FREQ);
  localparam int unsigned HALF = uart_half(CLK_FREQ, UART_FREQ);
  localparam logic [BAUD_W-1:0] DIV_M1  = BAUD_W'(DIV - 1);
  localparam logic [BAUD_W-1:0] HALF_M1 = BAUD_W'(HALF - 1);

  uart_state_e state, state_nxt;

  logic              rx_meta, rx_s;
  logic [2:0]        bit_idx, bit_idx_nxt;
  logic [7:0]        shreg, shreg_nxt;
  logic [7:0]        data_nxt;
  logic              valid_nxt, frame_err_nxt;
  logic              baud_load;
  logic [BAUD_W-1:0] baud_val;
  logic              baud_tick;

`ifdef DBG_UART_RX_PARITY_EN
  logic par_bad, par_bad_nxt, parity_err_nxt;
`endif

  // Both synchronizer flops reset high so a reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  dbg_uart_baud #(
    .CNT_W(BAUD_W)
  ) u_baud (
    .clk     (clk),
    .reset   (reset),
    .load    (baud_load),
    .load_val(baud_val),
    .tick    (baud_tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      bit_idx   <= 3'd0;
      shreg     <= 8'h00;
      data      <= 8'h00;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      bit_idx   <= bit_idx_nxt;
      shreg     <= shreg_nxt;
      data      <= data_nxt;
      valid     <= valid_nxt;
      frame_err <= frame_err_nxt;
    end
  end

`ifdef DBG_UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      par_bad    <= par_bad_nxt;
      parity_err <= parity_err_nxt;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

  always_comb begin
    state_nxt     = state;
    bit_idx_nxt   = bit_idx;
    shreg_nxt     = shreg;
    data_nxt      = data;
    valid_nxt     = 1'b0;
    frame_err_nxt = 1'b0;
    baud_load     = 1'b0;
    baud_val      = DIV_M1;
`ifdef DBG_UART_RX_PARITY_EN
    par_bad_nxt    = par_bad;
    parity_err_nxt = 1'b0;
`endif

    case (state)
      ST_IDLE: begin
        if (!rx_s) begin
          state_nxt = ST_START;
          baud_load = 1'b1;
          baud_val  = HALF_M1;
        end
      end

      ST_START: begin
        if (baud_tick) begin
          if (!rx_s) begin
            state_nxt   = ST_DATA;
            bit_idx_nxt = 3'd0;
            baud_load   = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end

      ST_DATA: begin
        if (baud_tick) begin
          shreg_nxt   = {rx_s, shreg[7:1]};
          bit_idx_nxt = bit_idx + 3'd1;
          baud_load   = 1'b1;
          if (bit_idx == 3'd7) begin
`ifdef DBG_UART_RX_PARITY_EN
            state_nxt = ST_PARITY;
`else
            state_nxt = ST_STOP;
`endif
          end
        end
      end

`ifdef DBG_UART_RX_PARITY_EN
      ST_PARITY: begin
        if (baud_tick) begin
          // Even parity: data bits plus parity bit must XOR to zero.
          par_bad_nxt = rx_s ^ (^shreg);
          baud_load   = 1'b1;
          state_nxt   = ST_STOP;
        end
      end
`endif

      ST_STOP: begin
        if (baud_tick) begin
          if (rx_s) begin
            state_nxt = ST_IDLE;
`ifdef DBG_UART_RX_PARITY_EN
            if (par_bad) begin
              parity_err_nxt = 1'b1;
            end else begin
              valid_nxt = 1'b1;
              data_nxt  = shreg;
            end
`else
            valid_nxt = 1'b1;
            data_nxt  = shreg;
`endif
          end else begin
            frame_err_nxt = 1'b1;
            state_nxt     = ST_BREAK;
          end
        end
      end

      ST_BREAK: begin
        if (rx_s) begin
          state_nxt = ST_IDLE;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_dbg_uart_rx.sv
// Self-checking bench for dbg_uart_rx: table vectors, corner sequences and random
// frames compared against a frame-level model of what each transmitted frame must yield.
module tb_dbg_uart_rx;

  localparam int CLK_HALF = 500;
  localparam int BIT_T    = 8681;

`ifdef DBG_UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  dbg_uart_rx #(
    .CLK_FREQ (1000000),
    .UART_FREQ(115200)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .busy      (busy)
  );

  always #CLK_HALF clk = ~clk;

  typedef enum logic [1:0] {EV_VALID = 2'd0, EV_FERR = 2'd1, EV_PERR = 2'd2} ev_kind_e;
  typedef struct {
    ev_kind_e   kind;
    logic [7:0] data;
  } ev_t;
  typedef struct {
    logic [7:0] b;
    logic       stop_bit;
    logic       par_bit;
    ev_kind_e   exp_kind;
    logic [7:0] exp_data;
  } vec_t;

  ev_t        got_q[$];
  ev_t        exp_q[$];
  vec_t       vecs[$];
  int         errors    = 0;
  int         checks    = 0;
  int         excl_viol = 0;
  bit         busy_seen = 1'b0;
  logic [7:0] model_data;

  always @(negedge clk) begin
    if (valid)      got_q.push_back('{EV_VALID, data});
    if (frame_err)  got_q.push_back('{EV_FERR, data});
    if (parity_err) got_q.push_back('{EV_PERR, data});
    if (int'(valid) + int'(frame_err) + int'(parity_err) > 1) excl_viol++;
    if (busy) busy_seen = 1'b1;
  end

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic compare_events(input string name);
    check_val({name, " event count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) begin
        check_val($sformatf("%s ev%0d kind", name, i), 32'(got_q[i].kind), 32'(exp_q[i].kind));
        check_val($sformatf("%s ev%0d data", name, i), 32'(got_q[i].data), 32'(exp_q[i].data));
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  function automatic logic even_par(input logic [7:0] b);
    return ^b;
  endfunction

  // Frame-level reference: what a receiver must report for one transmitted frame.
  function automatic ev_t model_frame(input logic [7:0] b, input logic stop_bit, input logic par_bit);
    ev_t e;
    if (!stop_bit) begin
      e.kind = EV_FERR;
      e.data = model_data;
    end else if (PAR_EN && ((($countones(b) + int'(par_bit)) % 2) != 0)) begin
      e.kind = EV_PERR;
      e.data = model_data;
    end else begin
      e.kind     = EV_VALID;
      e.data     = b;
      model_data = b;
    end
    return e;
  endfunction

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_bit);
    rx = 1'b0;
    #BIT_T;
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #BIT_T;
    end
    if (PAR_EN) begin
      rx = par_bit;
      #BIT_T;
    end
    rx = stop_bit;
    #BIT_T;
    rx = 1'b1;
    if (!stop_bit) #(2 * BIT_T);
  endtask

  initial begin
    reset      = 1'b1;
    rx         = 1'b1;
    model_data = 8'h00;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_val("reset data", 32'(data), 32'h00);
    check_val("reset valid", 32'(valid), 32'h0);
    check_val("reset frame_err", 32'(frame_err), 32'h0);
    check_val("reset parity_err", 32'(parity_err), 32'h0);
    check_val("reset busy", 32'(busy), 32'h0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Back-to-back bytes, then a forced-low stop bit followed by a good byte.
    vecs.push_back('{8'h01, 1'b1, 1'b1, EV_VALID, 8'h01});
    vecs.push_back('{8'h80, 1'b1, 1'b1, EV_VALID, 8'h80});
    vecs.push_back('{8'h80, 1'b1, 1'b1, EV_VALID, 8'h80});
    vecs.push_back('{8'h80, 1'b1, 1'b1, EV_VALID, 8'h80});
    vecs.push_back('{8'h80, 1'b1, 1'b1, EV_VALID, 8'h80});
    vecs.push_back('{8'hA5, 1'b0, 1'b0, EV_FERR,  8'h80});
    vecs.push_back('{8'h3C, 1'b1, 1'b0, EV_VALID, 8'h3C});
`ifdef DBG_UART_RX_PARITY_EN
    vecs.push_back('{8'h07, 1'b1, 1'b1, EV_VALID, 8'h07});
    vecs.push_back('{8'h07, 1'b1, 1'b0, EV_PERR,  8'h07});
    vecs.push_back('{8'h5A, 1'b0, 1'b1, EV_FERR,  8'h07});
`endif
    for (int i = 0; i < vecs.size(); i++) begin
      exp_q.push_back('{vecs[i].exp_kind, vecs[i].exp_data});
      if (vecs[i].exp_kind == EV_VALID) model_data = vecs[i].exp_data;
      send_frame(vecs[i].b, vecs[i].stop_bit, vecs[i].par_bit);
    end
    #(2 * BIT_T);
    compare_events("table");

    // Short low glitch on an idle line must abort in START.
    busy_seen = 1'b0;
    @(negedge clk);
    rx = 1'b0;
    #(3 * 2 * CLK_HALF);
    rx = 1'b1;
    repeat (8) @(negedge clk);
    check_val("glitch busy seen", 32'(busy_seen), 32'h1);
    check_val("glitch busy after", 32'(busy), 32'h0);
    #(2 * BIT_T);
    compare_events("glitch");

    // Reset during bit 4 of 0xDD, held to the end of that frame.
    fork
      send_frame(8'hDD, 1'b1, even_par(8'hDD));
      begin
        #(5 * BIT_T + BIT_T / 2);
        @(negedge clk);
        reset = 1'b1;
      end
    join
    repeat (3) @(negedge clk);
    check_val("midreset data", 32'(data), 32'h00);
    check_val("midreset busy", 32'(busy), 32'h0);
    reset      = 1'b0;
    model_data = 8'h00;
    compare_events("midreset no strobe");
    repeat (4) @(negedge clk);
    exp_q.push_back(model_frame(8'hCC, 1'b1, even_par(8'hCC)));
    send_frame(8'hCC, 1'b1, even_par(8'hCC));
    #(2 * BIT_T);
    compare_events("after reset");

    // Line held low for 30 bit times: one frame error only, then a clean byte.
    @(negedge clk);
    exp_q.push_back(model_frame(8'h00, 1'b0, 1'b0));
    rx = 1'b0;
    #(30 * BIT_T);
    rx = 1'b1;
    #(2 * BIT_T);
    exp_q.push_back(model_frame(8'h55, 1'b1, even_par(8'h55)));
    send_frame(8'h55, 1'b1, even_par(8'h55));
    #(2 * BIT_T);
    compare_events("break");

    // Random frames, occasional bad stop bit / bad parity.
    for (int i = 0; i < 14; i++) begin
      logic [7:0] b;
      logic       sb;
      logic       pb;
      b  = 8'($urandom);
      sb = ($urandom_range(0, 5) != 0);
      pb = even_par(b) ^ ($urandom_range(0, 3) == 0);
      exp_q.push_back(model_frame(b, sb, pb));
      send_frame(b, sb, pb);
    end
    #(2 * BIT_T);
    compare_events("random");

    check_val("strobe exclusivity", 32'(excl_viol), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
